// File: rtl/fsm_sar_mc_if.sv
// Bus bundle for the multi-channel SAR controller: control inputs, comparator and DAC/mux/result outputs.
// Optional macro FSM_SAR_OVR_EN adds the ovr_o over/under-range flag.
interface fsm_sar_mc_if #(
   parameter int Width    = 8,
   parameter int Channels = 4
);
   localparam int ChBits = (Channels > 1) ? $clog2(Channels) : 1;

   logic                start_i;
   logic                cont_i;
   logic [Channels-1:0] chmask_i;
   logic                cmp_i;
   logic                sample_o;
   logic [ChBits-1:0]   chsel_o;
   logic [Width-1:0]    dac_o;
   logic [Width-1:0]    result_o;
   logic [ChBits-1:0]   ch_o;
   logic                eoc_o;
   logic                busy_o;
`ifdef FSM_SAR_OVR_EN
   logic                ovr_o;
`endif

   modport master (
      input  start_i, cont_i, chmask_i, cmp_i,
      output sample_o, chsel_o, dac_o, result_o, ch_o, eoc_o, busy_o
`ifdef FSM_SAR_OVR_EN
      , output ovr_o
`endif
   );

   modport slave (
      output start_i, cont_i, chmask_i, cmp_i,
      input  sample_o, chsel_o, dac_o, result_o, ch_o, eoc_o, busy_o
`ifdef FSM_SAR_OVR_EN
      , input ovr_o
`endif
   );
endinterface

// File: rtl/fsm_sar_mc.sv
// Multi-channel SAR ADC controller: masked round-robin scan, programmable sample time, tagged results.
// Optional macro FSM_SAR_OVR_EN registers an ovr_o flag for all-ones/all-zeros results.
module fsm_sar_mc #(
   parameter int Width        = 8,
   parameter int Channels     = 4,
   parameter int SampleCycles = 2
) (
   input logic          clk_i,
   input logic          rst_i,
   fsm_sar_mc_if.master bus
);
   localparam int ChBits  = (Channels > 1) ? $clog2(Channels) : 1;
   localparam int CntBits = (SampleCycles > 1) ? $clog2(SampleCycles) : 1;

   typedef enum logic [1:0] {IDLE, SAMPLE, CONV, DONE} state_t;

   state_t             state;
   logic [CntBits-1:0] sample_cnt;
   logic [Width-1:0]   trial;
   logic [Width-1:0]   kept;
   logic [ChBits-1:0]  low_ch;
   logic [ChBits-1:0]  above_ch;
   logic               has_above;
   logic [ChBits-1:0]  next_ch;
   logic               keep_going;

   // Descending scan: the last hit is the lowest match, giving both the wrap target and the next channel up.
   always_comb begin
      low_ch    = '0;
      above_ch  = '0;
      has_above = 1'b0;
      for (int i = Channels - 1; i >= 0; i--) begin
         if (bus.chmask_i[i]) begin
            low_ch = ChBits'(i);
            if (i > int'(bus.chsel_o)) begin
               above_ch  = ChBits'(i);
               has_above = 1'b1;
            end
         end
      end
      next_ch    = has_above ? above_ch : low_ch;
      keep_going = (|bus.chmask_i) && (bus.cont_i || has_above);
      kept       = bus.cmp_i ? bus.dac_o : (bus.dac_o & ~trial);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= IDLE;
         sample_cnt   <= '0;
         trial        <= '0;
         bus.sample_o <= 1'b0;
         bus.chsel_o  <= '0;
         bus.dac_o    <= '0;
         bus.result_o <= '0;
         bus.ch_o     <= '0;
         bus.eoc_o    <= 1'b0;
         bus.busy_o   <= 1'b0;
`ifdef FSM_SAR_OVR_EN
         bus.ovr_o    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.start_i && (|bus.chmask_i)) begin
                  state        <= SAMPLE;
                  sample_cnt   <= CntBits'(SampleCycles - 1);
                  bus.sample_o <= 1'b1;
                  bus.busy_o   <= 1'b1;
                  bus.chsel_o  <= low_ch;
               end
            end
            SAMPLE: begin
               if (sample_cnt == '0) begin
                  state        <= CONV;
                  bus.sample_o <= 1'b0;
                  bus.dac_o    <= {1'b1, {(Width-1){1'b0}}};
                  trial        <= {1'b1, {(Width-1){1'b0}}};
               end else begin
                  sample_cnt <= sample_cnt - 1'b1;
               end
            end
            // The one-hot trial register marks the bit under test; reaching bit 0 ends the conversion.
            CONV: begin
               if (trial[0]) begin
                  state        <= DONE;
                  bus.dac_o    <= '0;
                  bus.result_o <= kept;
                  bus.ch_o     <= bus.chsel_o;
                  bus.eoc_o    <= 1'b1;
`ifdef FSM_SAR_OVR_EN
                  bus.ovr_o    <= (&kept) | (~|kept);
`endif
               end else begin
                  bus.dac_o <= kept | (trial >> 1);
                  trial     <= trial >> 1;
               end
            end
            DONE: begin
               bus.eoc_o <= 1'b0;
               if (keep_going) begin
                  state        <= SAMPLE;
                  sample_cnt   <= CntBits'(SampleCycles - 1);
                  bus.sample_o <= 1'b1;
                  bus.chsel_o  <= next_ch;
               end else begin
                  state      <= IDLE;
                  bus.busy_o <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
